// File: rtl/phv_field_deposit.sv
// Per-stage PHV write-back: deposits up to NUM_OPS container writes from an
// action bundle into the PHV and hands the result downstream via valid/ready.
`timescale 1ns/1ps
module phv_field_deposit #(
  parameter int PHV_LEN  = 48*8 + 32*8 + 16*8 + 256,
  parameter int NUM_OPS  = 4,
  parameter int OP_W     = 54,
  parameter int STAGE_ID = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PHV_LEN-1:0]        phv_in,
  input  logic [NUM_OPS*OP_W-1:0]   action_in,
  input  logic                      phv_valid_in,
  output logic                      ready_out,
  output logic [PHV_LEN-1:0]        phv_out,
  output logic                      phv_valid_out,
  input  logic                      ready_in,
  output logic [31:0]               phv_cnt
);

  localparam int META_W  = 256;
  localparam int B2_BASE = META_W;
  localparam int B4_BASE = B2_BASE + 16*8;
  localparam int B6_BASE = B4_BASE + 32*8;

  if (STAGE_ID < 0) begin : g_bad_stage
    $error("phv_field_deposit: STAGE_ID must be non-negative");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                    state_r;
  state_e                    state_nx_s;
  logic                      capture_s;
  logic                      load_out_s;
  logic                      release_s;
  logic [PHV_LEN-1:0]        phv_r;
  logic [NUM_OPS*OP_W-1:0]   act_r;
  logic [PHV_LEN-1:0]        phv_out_r;
  logic                      phv_valid_out_r;
  logic [31:0]               phv_cnt_r;

  // Ops are applied in ascending k so the highest enabled k wins a collision;
  // value bits above the container width are dropped by the part-select width.
  function automatic logic [PHV_LEN-1:0] deposit_ops(
    input logic [PHV_LEN-1:0]      phv,
    input logic [NUM_OPS*OP_W-1:0] act
  );
    logic [PHV_LEN-1:0] res;
    logic [OP_W-1:0]    op;
    int                 idx;
    res = phv;
    for (int k = 0; k < NUM_OPS; k++) begin
      op  = act[k*OP_W +: OP_W];
      idx = int'(op[50:48]);
      if (op[53]) begin
        case (op[52:51])
          2'b10:   res[B6_BASE + idx*48 +: 48] = op[47:0];
          2'b01:   res[B4_BASE + idx*32 +: 32] = op[31:0];
          2'b00:   res[B2_BASE + idx*16 +: 16] = op[15:0];
          default: res = res;
        endcase
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state and per-state strobes
  always_comb begin
    state_nx_s = state_r;
    capture_s  = 1'b0;
    load_out_s = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (phv_valid_in) begin
          state_nx_s = APPLY;
          capture_s  = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      APPLY: begin
        state_nx_s = HOLD;
        load_out_s = 1'b1;
      end
      HOLD: begin
        if (ready_in) begin
          state_nx_s = IDLE;
          release_s  = 1'b1;
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, captured beat and output registers; reset drops any in-flight PHV
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      phv_r           <= '0;
      act_r           <= '0;
      phv_out_r       <= '0;
      phv_valid_out_r <= 1'b0;
      phv_cnt_r       <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      if (capture_s) begin
        phv_r <= phv_in;
        act_r <= action_in;
      end
      if (load_out_s) begin
        phv_out_r       <= deposit_ops(phv_r, act_r);
        phv_valid_out_r <= 1'b1;
      end else if (release_s) begin
        phv_valid_out_r <= 1'b0;
        phv_cnt_r       <= phv_cnt_r + 32'd1;
      end
    end
  end

  assign ready_out     = (state_r == IDLE);
  assign phv_out       = phv_out_r;
  assign phv_valid_out = phv_valid_out_r;
  assign phv_cnt       = phv_cnt_r;

endmodule

// File: tb/tb_phv_field_deposit.sv
// Scoreboard bench for phv_field_deposit: expected PHVs are queued on accept
// and compared when the DUT hands a PHV downstream.
`timescale 1ns/1ps
module tb_phv_field_deposit;

  localparam int PHV_LEN = 1024;
  localparam int NUM_OPS = 4;
  localparam int OP_W    = 54;
  localparam int ACT_W   = NUM_OPS*OP_W;
  localparam int B6 = 640;
  localparam int B4 = 384;
  localparam int B2 = 256;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PHV_LEN-1:0] phv_in = '0;
  logic [ACT_W-1:0]   action_in = '0;
  logic               phv_valid_in = 1'b0;
  logic               ready_out;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out;
  logic               ready_in = 1'b0;
  logic [31:0]        phv_cnt;

  int                 vec_cnt = 0;
  int                 err_cnt = 0;
  int                 xfer_cnt = 0;
  logic [PHV_LEN-1:0] sb_q[$];
  logic [PHV_LEN-1:0] last_out = '0;

  always #5 clk = ~clk;

  phv_field_deposit #(.PHV_LEN(PHV_LEN), .NUM_OPS(NUM_OPS), .OP_W(OP_W), .STAGE_ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .phv_in(phv_in), .action_in(action_in),
    .phv_valid_in(phv_valid_in), .ready_out(ready_out), .phv_out(phv_out),
    .phv_valid_out(phv_valid_out), .ready_in(ready_in), .phv_cnt(phv_cnt)
  );

  task automatic check_val(input string tag, input logic [PHV_LEN-1:0] obs, input logic [PHV_LEN-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] mkop(input logic en, input logic [1:0] ty,
                                           input logic [2:0] idx, input logic [47:0] v);
    return {en, ty, idx, v};
  endfunction

  // Reference model: container layout written out from the PHV map
  function automatic logic [PHV_LEN-1:0] model(input logic [PHV_LEN-1:0] p, input logic [ACT_W-1:0] a);
    logic [OP_W-1:0] op;
    for (int k = 0; k < NUM_OPS; k++) begin
      op = a[k*OP_W +: OP_W];
      if (op[53]) begin
        if (op[52:51] == 2'd2) p[B6 + 48*int'(op[50:48]) +: 48] = op[47:0];
        if (op[52:51] == 2'd1) p[B4 + 32*int'(op[50:48]) +: 32] = op[31:0];
        if (op[52:51] == 2'd0) p[B2 + 16*int'(op[50:48]) +: 16] = op[15:0];
      end
    end
    return p;
  endfunction

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] r;
    for (int i = 0; i < PHV_LEN/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [ACT_W-1:0] rand_act();
    logic [ACT_W-1:0] r;
    for (int k = 0; k < NUM_OPS; k++)
      r[k*OP_W +: OP_W] = mkop(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               3'($urandom_range(0, 7)), {16'($urandom()), 32'($urandom())});
    return r;
  endfunction

  // Transfer monitor: a handshake completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && phv_valid_out === 1'b1 && ready_in === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_out", PHV_LEN'(phv_valid_out), PHV_LEN'(0));
      end else begin
        check_val("phv_out", phv_out, sb_q.pop_front());
        check_val("rdy_out_in_hold", PHV_LEN'(ready_out), PHV_LEN'(0));
        last_out = phv_out;
        xfer_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PHV_LEN-1:0] p, input logic [ACT_W-1:0] a);
    int n = 0;
    while (ready_out !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    if (ready_out !== 1'b1) check_val("send_timeout", PHV_LEN'(ready_out), PHV_LEN'(1));
    phv_in = p;
    action_in = a;
    phv_valid_in = 1'b1;
    sb_q.push_back(model(p, a));
    cyc();
    phv_valid_in = 1'b0;
  endtask

  task automatic drain(input bit rnd_rdy);
    int n = 0;
    while ((sb_q.size() != 0 || phv_valid_out === 1'b1) && n < 200) begin
      ready_in = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    ready_in = 1'b1;
    check_val("drain_empty", PHV_LEN'(sb_q.size()), PHV_LEN'(0));
    check_val("phv_cnt", PHV_LEN'(phv_cnt), PHV_LEN'(xfer_cnt));
  endtask

  initial begin
    logic [PHV_LEN-1:0] e, p, exp_a;
    logic [ACT_W-1:0]   a;
    logic [31:0]        cnt0;
    int                 n;

    repeat (3) cyc();
    rst_n = 1'b1;
    check_val("rst_phv_out", phv_out, '0);
    check_val("rst_valid", PHV_LEN'(phv_valid_out), PHV_LEN'(0));
    check_val("rst_cnt", PHV_LEN'(phv_cnt), PHV_LEN'(0));
    check_val("rst_ready", PHV_LEN'(ready_out), PHV_LEN'(1));
    cyc();
    check_val("idle_ready", PHV_LEN'(ready_out), PHV_LEN'(1));

    // Single 6B write into the top container, with latency checks
    ready_in = 1'b1;
    a = '0;
    a[0 +: OP_W] = mkop(1'b1, 2'd2, 3'd7, 48'hAABBCCDDEEFF);
    send('0, a);
    check_val("lat_accept_edge", PHV_LEN'(phv_valid_out), PHV_LEN'(0));
    check_val("busy_after_accept", PHV_LEN'(ready_out), PHV_LEN'(0));
    cyc();
    check_val("lat_second_edge", PHV_LEN'(phv_valid_out), PHV_LEN'(1));
    e = '0;
    e[PHV_LEN-1 -: 48] = 48'hAABBCCDDEEFF;
    check_val("single6B", phv_out, e);
    drain(1'b0);
    check_val("cnt_one", PHV_LEN'(phv_cnt), PHV_LEN'(1));

    // Truncation and ignored type 3
    a = '0;
    a[0*OP_W +: OP_W] = mkop(1'b1, 2'd1, 3'd0, 48'h123456789ABC);
    a[1*OP_W +: OP_W] = mkop(1'b1, 2'd0, 3'd3, 48'h0000FFFF0001);
    a[2*OP_W +: OP_W] = mkop(1'b1, 2'd3, 3'd5, 48'hDEADBEEFCAFE);
    send('0, a);
    drain(1'b0);
    e = '0;
    e[B4 +: 32] = 32'h56789ABC;
    e[B2 + 48 +: 16] = 16'h0001;
    check_val("trunc_4B", PHV_LEN'(last_out[B4 +: 32]), PHV_LEN'(32'h56789ABC));
    check_val("trunc_2B", PHV_LEN'(last_out[B2 + 48 +: 16]), PHV_LEN'(16'h0001));
    check_val("trunc_full", last_out, e);

    // Collision on 2B[5]: op3 wins, disabled ops and metadata untouched
    a = '0;
    a[0*OP_W +: OP_W] = mkop(1'b1, 2'd0, 3'd5, 48'h1111);
    a[1*OP_W +: OP_W] = mkop(1'b0, 2'd2, 3'd5, 48'h555555555555);
    a[2*OP_W +: OP_W] = mkop(1'b0, 2'd0, 3'd5, 48'h3333);
    a[3*OP_W +: OP_W] = mkop(1'b1, 2'd0, 3'd5, 48'h2222);
    send('1, a);
    drain(1'b0);
    e = '1;
    e[B2 + 80 +: 16] = 16'h2222;
    check_val("collide_2B5", PHV_LEN'(last_out[B2 + 80 +: 16]), PHV_LEN'(16'h2222));
    check_val("collide_meta", PHV_LEN'(last_out[255:0]), PHV_LEN'({256{1'b1}}));
    check_val("collide_full", last_out, e);

    // Minimum spacing: back in IDLE two edges after the accept edge
    send(rand_phv(), rand_act());
    n = 0;
    while (ready_out !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check_val("spacing", PHV_LEN'(n), PHV_LEN'(2));
    drain(1'b0);

    // Backpressure with a second beat waiting upstream
    ready_in = 1'b0;
    p = rand_phv();
    a = rand_act();
    exp_a = model(p, a);
    send(p, a);
    n = 0;
    while (phv_valid_out !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    check_val("bp_valid_rise", PHV_LEN'(phv_valid_out), PHV_LEN'(1));
    p = rand_phv();
    a = rand_act();
    phv_in = p;
    action_in = a;
    phv_valid_in = 1'b1;
    cnt0 = phv_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_val("bp_hold_data", phv_out, exp_a);
      check_val("bp_hold_valid", PHV_LEN'(phv_valid_out), PHV_LEN'(1));
      check_val("bp_hold_ready", PHV_LEN'(ready_out), PHV_LEN'(0));
    end
    ready_in = 1'b1;
    cyc();
    check_val("bp_after_xfer_ready", PHV_LEN'(ready_out), PHV_LEN'(1));
    check_val("bp_after_xfer_valid", PHV_LEN'(phv_valid_out), PHV_LEN'(0));
    check_val("bp_cnt_once", PHV_LEN'(phv_cnt), PHV_LEN'(cnt0 + 32'd1));
    sb_q.push_back(model(p, a));
    cyc();
    phv_valid_in = 1'b0;
    check_val("bp_second_capt", PHV_LEN'(ready_out), PHV_LEN'(0));
    drain(1'b0);
    check_val("bp_cnt_twice", PHV_LEN'(phv_cnt), PHV_LEN'(cnt0 + 32'd2));

    // Random beats with random downstream stalls
    for (int i = 0; i < 16; i++) begin
      send(rand_phv(), rand_act());
      drain(1'b1);
    end

    // Reset while in APPLY: in-flight PHV is dropped
    ready_in = 1'b1;
    send(rand_phv(), rand_act());
    rst_n = 1'b0;
    sb_q.delete();
    cyc();
    check_val("mid_rst_valid", PHV_LEN'(phv_valid_out), PHV_LEN'(0));
    check_val("mid_rst_phv", phv_out, '0);
    check_val("mid_rst_ready", PHV_LEN'(ready_out), PHV_LEN'(1));
    check_val("mid_rst_cnt", PHV_LEN'(phv_cnt), PHV_LEN'(0));
    xfer_cnt = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check_val("no_stale_valid", PHV_LEN'(phv_valid_out), PHV_LEN'(0));
    end
    send(rand_phv(), rand_act());
    drain(1'b0);
    check_val("post_rst_cnt", PHV_LEN'(phv_cnt), PHV_LEN'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
